// File: rtl/i_sram_line_packer.sv
// Instruction SRAM fill stage: packs WORDS_PER_LINE words into one line and issues
// one single-cycle write per completed (or flushed) line, tracking the write pointer.
module i_sram_line_packer #(
   parameter int WORD_W         = 48,
   parameter int WORDS_PER_LINE = 5,
   parameter int DEPTH          = 200,
   parameter int ADDR_W         = 8,
   parameter bit WRAP           = 1'b0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             cfg_load,
   input  logic [ADDR_W-1:0]                cfg_base,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WORD_W-1:0]                in_data,
   input  logic                             in_last,
   output logic                             WE,
   output logic [ADDR_W-1:0]                WriteAddress,
   output logic [WORD_W*WORDS_PER_LINE-1:0] WriteBus,
   output logic [ADDR_W:0]                  lines_written,
   output logic                             full,
   output logic                             flush_done
);

   localparam int LINE_W = WORD_W * WORDS_PER_LINE;
   localparam int IDX_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      S_RUN,
      S_FULL
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    idx;
   logic [LINE_W-1:0]   pack;
   logic [LINE_W-1:0]   line_next;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_inc;
   logic                accept;
   logic                line_done;
   logic                at_end;
   logic                base_ok;

   always_ff @(posedge clock) begin
      if (reset) state <= S_RUN;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      in_ready   = (state == S_RUN) & ~cfg_load & ~reset;
      accept     = in_valid & in_ready;
      line_done  = accept & (in_last | (idx == LAST_IDX));
      at_end     = (ptr == LAST_ADDR);
      if (cfg_load) state_next = S_RUN;
      else if (line_done && at_end && !WRAP) state_next = S_FULL;
   end

   always_comb begin
      line_next                       = pack;
      line_next[WORD_W*idx +: WORD_W] = in_data;
      ptr_inc                         = at_end ? '0 : ptr + 1'b1;
      base_ok                         = 32'(cfg_base) < DEPTH;
   end

   assign full = (state == S_FULL);

   // Slots above the current index are always zero, so a flushed partial line
   // needs no extra masking.
   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx           <= '0;
         pack          <= '0;
         ptr           <= '0;
         WE            <= 1'b0;
         WriteAddress  <= '0;
         WriteBus      <= '0;
         lines_written <= '0;
         flush_done    <= 1'b0;
      end else begin
         WE         <= 1'b0;
         flush_done <= 1'b0;
         if (cfg_load) begin
            idx           <= '0;
            pack          <= '0;
            ptr           <= base_ok ? cfg_base : '0;
            lines_written <= '0;
         end else if (accept) begin
            if (line_done) begin
               WE           <= 1'b1;
               WriteAddress <= ptr;
               WriteBus     <= line_next;
               flush_done   <= in_last;
               idx          <= '0;
               pack         <= '0;
               ptr          <= ptr_inc;
               if (lines_written != '1) lines_written <= lines_written + 1'b1;
            end else begin
               idx  <= idx + 1'b1;
               pack <= line_next;
            end
         end
      end
   end

endmodule

// File: doc/i_sram_line_packer.md
Name: i_sram_line_packer

Overview:
- Fill stage directly upstream of the instruction SRAM (240-bit lines, 200 entries, 1 write port).
- Accepts a stream of 48-bit instruction words over a valid/ready handshake.
- Packs 5 words into one 240-bit line and drives the SRAM write port (WE, WriteAddress, WriteBus) with one single-cycle write per completed line.
- Maintains the write pointer, handles partial-line flush, and stops or wraps when the array is exhausted.

Parameters:
- WORD_W, 48, input word width.
- WORDS_PER_LINE, 5, words per SRAM line; WORD_W*WORDS_PER_LINE = 240.
- DEPTH, 200, number of SRAM lines.
- ADDR_W, 8, SRAM address width.
- WRAP, 0: 1 = pointer wraps to 0 after line DEPTH-1; 0 = block stops (FULL).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  pulse: restart packing at cfg_base.
- cfg_base  in  ADDR_W  start line address, sampled when cfg_load=1.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  instruction word.
- in_last  in  1  word ends the stream; flush a partial line.
- WE  out  1  SRAM write enable, one-cycle pulse per line.
- WriteAddress  out  ADDR_W  SRAM line address.
- WriteBus  out  WORD_W*WORDS_PER_LINE  packed line.
- lines_written  out  ADDR_W+1  lines written since reset or cfg_load (saturating).
- full  out  1  high in FULL state.
- flush_done  out  1  one-cycle pulse when the line containing in_last is written.

Behaviour:
- Reset (reset=1 at a clock edge), all outputs registered:
  - WE=0, WriteAddress=0, WriteBus=0, lines_written=0, full=0, flush_done=0.
  - Word index=0, packing register cleared, pointer=0, state RUN.
  - Reset overrides every other input in the same cycle.
- Reset mid-line discards all packed words; no write is issued for them.
- in_ready = (state==RUN) & ~cfg_load & ~reset. This is combinational from state. A word transfers when in_valid & in_ready at a rising edge.
- States:
  - RUN: accepting words.
  - FULL (WRAP=0 only): in_ready=0 and full=1. Left only via cfg_load or reset.
- Packing: the word accepted at index k (0..4) goes to line bits [WORD_W*k +: WORD_W]. Index increments per accepted word.
- Line completion: the accepted word has index 4, or in_last=1. For a partial line (in_last with k<4), bits above word k are zero.
- Write timing: if a word completes a line at edge t, then in the cycle following edge t:
  - WE=1, WriteAddress=pointer, WriteBus=line.
  - The packing register clears, index returns to 0, pointer advances, and lines_written increments (saturating at 2^(ADDR_W+1)-1).
- The next word may be accepted on the very edge following the completing word. Back-to-back lines therefore yield back-to-back WE pulses, 5 cycles apart at full rate. No stall cycle is inserted.
- flush_done=1 in the same cycle as the WE of an in_last line.
- WE is 0 in every other cycle. WriteAddress and WriteBus hold their last written values while WE=0.
- Pointer boundary after writing line DEPTH-1:
  - WRAP=1: pointer becomes 0, state stays RUN.
  - WRAP=0: state becomes FULL, so in_ready=0 from the cycle of that WE onward.
- cfg_load:
  - Pointer becomes cfg_base. If cfg_base >= DEPTH, pointer becomes 0.
  - Index=0, packing register cleared, lines_written=0, state RUN, full=0.
  - Any partially packed words are discarded without a write.
  - in_ready=0 during the cfg_load cycle, so no word is accepted.
  - A WE already scheduled by the previous edge is still emitted, with its old address.
- in_valid with in_ready=0: the word is not consumed; the producer holds it.
- in_last=1 with index 4 behaves as a normal full line plus flush_done.

Test Plan:
- Reset, then 10 words 0x000000000001..0x00000000000A with no gaps -> WE at cycle after word 5 (addr 0, WriteBus[47:0]=1, [239:192]=5) and after word 10 (addr 1); lines_written=2.
- 2 words (0xAAAA, 0xBBBB) with in_last on 2nd -> one WE, addr 0, WriteBus[47:0]=0xAAAA, [95:48]=0xBBBB, [239:96]=0; flush_done pulses with WE.
- WRAP=0, cfg_load cfg_base=198, stream 15 words -> writes to 198,199; full=1 and in_ready=0 from WE of 199; remaining 5 words held, no WE; cfg_load base=0 -> in_ready=1.
- WRAP=1, cfg_base=199, 10 words -> writes to 199 then 0; full stays 0.
- 3 words accepted, then cfg_load base=10 with in_valid=1 -> no WE, word not consumed that cycle; next 5 words write line at addr 10 containing only new words.
- 4 words accepted, then reset asserted for 1 cycle -> no WE, all outputs 0; next 5 words write addr 0.
